// File: rtl/coffee_pkg.sv
// coffee_pkg
//   Shared definitions for the coffee machine: drink and ingredient codes,
//   the dispense-timer state encoding and the recipe duration table.
//   Used by the brew sequencer, the billing block and dispense_timer.
//   recipe_secs(drink, ing) returns the dispense time in seconds, or 0 for
//   any code outside the table.
package coffee_pkg;

  typedef enum logic [2:0] {
    DRINK_NONE = 3'd0,
    DRINK_C1   = 3'd1,
    DRINK_C2   = 3'd2,
    DRINK_C3   = 3'd3,
    DRINK_C4   = 3'd4,
    DRINK_C5   = 3'd5
  } drink_t;

  typedef enum logic [2:0] {
    ING_NONE   = 3'd0,
    ING_WATER  = 3'd1,
    ING_COFFEE = 3'd2,
    ING_MILK   = 3'd3,
    ING_CHOC   = 3'd4,
    ING_SUGAR  = 3'd5
  } ingredient_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2,
    HOLD  = 2'd3
  } timer_state_t;

  localparam int N_CODES = 5;

  // Row = drink c1..c5, column = water, coffee, milk, chocolate, sugar.
  localparam logic [3:0] RECIPE_SECS [N_CODES][N_CODES] = '{
    '{4'd3, 4'd2, 4'd0, 4'd0, 4'd1},
    '{4'd5, 4'd2, 4'd0, 4'd0, 4'd1},
    '{4'd2, 4'd2, 4'd4, 4'd0, 4'd1},
    '{4'd2, 4'd2, 4'd3, 4'd2, 4'd2},
    '{4'd2, 4'd1, 4'd2, 4'd0, 4'd0}
  };

  function automatic logic [7:0] recipe_secs(input logic [2:0] drink,
                                             input logic [2:0] ing);
    logic [7:0] secs;
    secs = '0;
    if (drink >= 3'd1 && drink <= 3'd5 && ing >= 3'd1 && ing <= 3'd5) begin
      secs = {4'b0000, RECIPE_SECS[drink - 3'd1][ing - 3'd1]};
    end
    return secs;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen
//   One-second prescaler. Counts 0..TICK_DIV-1 while enable is high and
//   raises tick for the cycle in which the count wraps.
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset, clears the count
//   clear  : synchronous restart of the count from 0
//   enable : count advances only while high
//   tick   : one-cycle pulse at wrap
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  generate
    if (TICK_DIV <= 1) begin : g_every_cycle
      // A divide-by-one prescaler has no state: every enabled cycle ticks.
      assign tick = enable & ~clear;
    end else begin : g_counter
      localparam int CW = $clog2(TICK_DIV);
      localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          wrap;

      assign wrap = (cnt_q == LAST);
      assign tick = enable & ~clear & wrap;

      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (enable) begin
          cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/dispense_timer.sv
// dispense_timer
//   Times one ingredient dispense. A rising edge of start_timer in IDLE
//   latches the recipe duration for (c_type, ing_type) and counts it down
//   in seconds; at the end t_expired pulses once. The block then waits for
//   start_timer to drop before it can be started again. Dropping
//   start_timer while counting aborts the run silently.
//   clk         : clock, rising edge
//   reset       : asynchronous active-high reset
//   start_timer : level, high while the sequencer is in a dispense state
//   ing_type    : ingredient code 1..5
//   c_type      : drink code 1..5
//   t_expired   : registered one-cycle end-of-dispense pulse
//   busy        : high while counting
//   remaining   : seconds left, for the display
module dispense_timer
  import coffee_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int DUR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_timer,
  input  logic [2:0]       ing_type,
  input  logic [2:0]       c_type,
  output logic             t_expired,
  output logic             busy,
  output logic [DUR_W-1:0] remaining
);

  timer_state_t     state_q, state_d;
  logic             start_prev_q, start_prev_d;
  logic [DUR_W-1:0] remaining_q, remaining_d;
  logic             t_expired_q, t_expired_d;

  logic             start_rise;
  logic             presc_clear;
  logic             presc_en;
  logic             tick;
  logic [DUR_W-1:0] duration;

  assign duration   = DUR_W'(recipe_secs(c_type, ing_type));
  assign start_rise = start_timer & ~start_prev_q;
  assign presc_en   = (state_q == COUNT);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (presc_clear),
    .enable(presc_en),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    start_prev_d = start_timer;
    // The pulse is registered from DONE, so it lands one cycle after the
    // final tick (D*TICK_DIV+1 cycles after the start edge).
    t_expired_d  = (state_q == DONE);
    presc_clear  = 1'b0;

    unique case (state_q)
      IDLE: begin
        remaining_d = '0;
        if (start_rise) begin
          presc_clear = 1'b1;
          remaining_d = duration;
          state_d     = (duration == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        // Abort wins over a coincident tick: no pulse once start drops.
        if (!start_timer) begin
          remaining_d = '0;
          state_d     = IDLE;
        end else if (tick) begin
          if (remaining_q == DUR_W'(1)) begin
            remaining_d = '0;
            state_d     = DONE;
          end else begin
            remaining_d = remaining_q - DUR_W'(1);
          end
        end
      end
      DONE: begin
        remaining_d = '0;
        state_d     = HOLD;
      end
      HOLD: begin
        remaining_d = '0;
        if (!start_timer) begin
          state_d = IDLE;
        end
      end
      default: begin
        remaining_d = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      remaining_q  <= '0;
      t_expired_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      remaining_q  <= remaining_d;
      t_expired_q  <= t_expired_d;
    end
  end

  assign t_expired = t_expired_q;
  assign busy      = (state_q == COUNT);
  assign remaining = remaining_q;

endmodule

// File: tb/tb_dispense_timer.sv
// tb_dispense_timer
//   Directed and randomized runs of dispense_timer with TICK_DIV=4. Expected
//   behaviour comes from the recipe table and the timing rule "remaining is
//   D - floor(k/TICK_DIV) k cycles after the start edge, pulse at
//   k = D*TICK_DIV+1".
module tb_dispense_timer;

  localparam int TD = 4;

  logic       clk;
  logic       reset;
  logic       start_timer;
  logic [2:0] ing_type;
  logic [2:0] c_type;
  logic       t_expired;
  logic       busy;
  logic [7:0] remaining;

  int errors = 0;
  int checks = 0;
  int tbl [1:5][1:5];

  dispense_timer #(
    .TICK_DIV(TD),
    .DUR_W   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_timer(start_timer),
    .ing_type   (ing_type),
    .c_type     (c_type),
    .t_expired  (t_expired),
    .busy       (busy),
    .remaining  (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_dur(input int c, input int ing);
    if (c < 1 || c > 5 || ing < 1 || ing > 5) return 0;
    return tbl[c][ing];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full dispense: raise start, follow it 20 cycles past expiry, then
  // drop start for one cycle so the timer is back in IDLE.
  task automatic do_run(input int c, input int ing, input bit scramble);
    int d, pulses, pulse_at, last;
    d        = ref_dur(c, ing);
    pulses   = 0;
    pulse_at = -1;
    last     = d * TD + 21;
    c_type      = 3'(c);
    ing_type    = 3'(ing);
    start_timer = 1'b1;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      if (t_expired === 1'b1) begin
        pulses++;
        pulse_at = k;
      end
      if (k == 0 || k == d * TD || (k % TD) == 1) begin
        check("remaining", remaining, (k < d * TD) ? (d - k / TD) : 0);
        check("busy", busy, (k < d * TD) ? 1 : 0);
      end
      if (scramble) begin
        c_type   = 3'($urandom_range(0, 7));
        ing_type = 3'($urandom_range(0, 7));
      end
    end
    check("pulse_count", pulses, 1);
    check("pulse_cycle", pulse_at, d * TD + 1);
    $display("run c=%0d ing=%0d dur=%0d pulses=%0d pulse_at=%0d",
             c, ing, d, pulses, pulse_at);
    start_timer = 1'b0;
    @(posedge clk); #1;
    check("idle_remaining", remaining, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int pulses;

    tbl[1] = '{3, 2, 0, 0, 1};
    tbl[2] = '{5, 2, 0, 0, 1};
    tbl[3] = '{2, 2, 4, 0, 1};
    tbl[4] = '{2, 2, 3, 2, 2};
    tbl[5] = '{2, 1, 2, 0, 0};

    reset       = 1'b1;
    start_timer = 1'b0;
    c_type      = 3'd0;
    ing_type    = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_t_expired", t_expired, 0);
    check("rst_busy", busy, 0);
    check("rst_remaining", remaining, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 0);

    // 4 s milk for drink 3, held high past expiry.
    do_run(3, 3, 1'b1);
    // Zero-duration sugar for drink 5.
    do_run(5, 5, 1'b0);
    // Invalid codes give zero duration.
    do_run(6, 1, 1'b0);
    do_run(2, 0, 1'b0);

    // Abort: drop start_timer partway through a 3 s run.
    c_type      = 3'd1;
    ing_type    = 3'd1;
    start_timer = 1'b1;
    pulses      = 0;
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk); #1;
      if (t_expired === 1'b1) pulses++;
    end
    check("abort_pre_remaining", remaining, 2);
    start_timer = 1'b0;
    @(posedge clk); #1;
    check("abort_remaining", remaining, 0);
    check("abort_busy", busy, 0);
    repeat (20) begin
      @(posedge clk); #1;
      if (t_expired === 1'b1) pulses++;
    end
    check("abort_pulses", pulses, 0);
    $display("run abort c=1 ing=1 pulses=%0d", pulses);

    // Reset in the middle of a count with remaining=2.
    start_timer = 1'b1;
    pulses      = 0;
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk); #1;
    end
    check("mid_rst_pre_remaining", remaining, 2);
    reset = 1'b1;
    #1;
    check("mid_rst_remaining", remaining, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_t_expired", t_expired, 0);
    start_timer = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (t_expired === 1'b1) pulses++;
    end
    check("mid_rst_pulses", pulses, 0);
    check("mid_rst_idle_remaining", remaining, 0);
    $display("run reset_mid_count pulses=%0d", pulses);

    // Full drink 4: every ingredient with a one-cycle low gap.
    for (int ing = 1; ing <= 5; ing++) begin
      do_run(4, ing, 1'b0);
    end

    // Randomized runs, codes include out-of-table values.
    for (int n = 0; n < 20; n++) begin
      do_run(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b1);
    end

    // start_timer already high while reset releases counts as an edge.
    reset       = 1'b1;
    start_timer = 1'b1;
    c_type      = 3'd1;
    ing_type    = 3'd1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rel_edge_remaining", remaining, 3);
    check("rel_edge_busy", busy, 1);
    pulses = 0;
    for (int k = 1; k <= 3 * TD + 3; k++) begin
      @(posedge clk); #1;
      if (t_expired === 1'b1) begin
        pulses++;
        check("rel_edge_pulse_cycle", k, 3 * TD + 1);
      end
    end
    check("rel_edge_pulses", pulses, 1);
    $display("run start_high_at_reset_release pulses=%0d", pulses);
    start_timer = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
